example_program_loader: RTL

- Upstream of the COMPUTER block. Drives its instruction-ROM write port (unit/code/write strobe) from one of two sources:
  - the on-board code switches, for a manual single-byte write;
  - one of four built-in example programs, selected by program[1:0] and streamed in on a send press.
- Sits between the board buttons/switches and the ROM write interface.
- Reports busy/done to the top level.

---
 rtl/example_program_pkg.sv | 54 +++++
 rtl/example_program_rom.sv | 25 ++
 rtl/example_program_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/example_program_pkg.sv
// Shared types, demo program images and the reference byte lookup for the
// example program loader.
package example_program_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StManual,
    StClear,
    StLoad,
    StFin
  } state_e;

  localparam int unsigned PROG_W       = 8;
  localparam int unsigned PROG_MAX_LEN = 16;
  // Index bits needed to address the longest program.
  localparam int unsigned PROG_IDX_W   = 4;

  localparam int unsigned PROG_LEN [4] = '{8, 12, 16, 4};

  localparam logic [PROG_W-1:0] PROG0 [8] = '{
    8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78
  };

  localparam logic [PROG_W-1:0] PROG1 [12] = '{
    8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5,
    8'hA6, 8'hA7, 8'hA8, 8'hA9, 8'hAA, 8'hAB
  };

  localparam logic [PROG_W-1:0] PROG2 [16] = '{
    8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7,
    8'hC8, 8'hC9, 8'hCA, 8'hCB, 8'hCC, 8'hCD, 8'hCE, 8'hCF
  };

  localparam logic [PROG_W-1:0] PROG3 [4] = '{
    8'hE3, 8'h5A, 8'h3C, 8'hFF
  };

  // Byte idx of program sel; zero past the end of the program.
  function automatic logic [PROG_W-1:0] prog_byte(input logic [1:0] sel,
                                                  input int unsigned idx);
    logic [PROG_W-1:0] b;
    b = '0;
    if (idx < PROG_LEN[sel]) begin
      case (sel)
        2'd0:    b = PROG0[idx[2:0]];
        2'd1:    b = PROG1[idx[3:0]];
        2'd2:    b = PROG2[idx[3:0]];
        default: b = PROG3[idx[1:0]];
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/example_program_rom.sv
// Combinational lookup of one byte of a built-in example program.
module example_program_rom
  import example_program_pkg::*;
#(
  parameter int unsigned IDX_W = 8
) (
  input  logic [1:0]        sel,
  input  logic [IDX_W-1:0]  idx,
  output logic [PROG_W-1:0] data
);

  // Table select; indices past the program length read as zero.
  always_comb begin
    data = '0;
    if (32'(idx) < PROG_LEN[sel]) begin
      case (sel)
        2'd0:    data = PROG0[idx[2:0]];
        2'd1:    data = PROG1[idx[3:0]];
        2'd2:    data = PROG2[idx[3:0]];
        default: data = PROG3[idx[1:0]];
      endcase
    end
  end

endmodule

// File: rtl/example_program_loader.sv
// Drives the instruction-ROM write port either with one manual byte or with a
// clear-then-stream of a built-in example program, started by the send button.
// The program select port is program_sel because "program" is a reserved word.
module example_program_loader
  import example_program_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CLEAR_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic              edit,
  input  logic [1:0]        program_sel,
  input  logic [ADDR_W-1:0] unit,
  input  logic [DATA_W-1:0] code,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  if (CLEAR_DEPTH < 1 || CLEAR_DEPTH > (1 << ADDR_W)) begin : gen_bad_depth
    $error("CLEAR_DEPTH must be in 1..2**ADDR_W");
  end
  if (ADDR_W < PROG_IDX_W || PROG_MAX_LEN > (1 << ADDR_W)) begin : gen_bad_addr
    $error("ADDR_W too narrow for the example programs");
  end
  if (DATA_W < PROG_W) begin : gen_bad_data
    $error("DATA_W narrower than an example program byte");
  end

  logic              send_meta_q, send_sync_q, send_prev_q;
  logic              start;
  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [1:0]        prog_sel_q;
  logic [ADDR_W-1:0] rom_idx;
  logic [PROG_W-1:0] rom_data;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      send_meta_q <= 1'b0;
      send_sync_q <= 1'b0;
      send_prev_q <= 1'b0;
    end else begin
      send_meta_q <= send;
      send_sync_q <= send_meta_q;
      send_prev_q <= send_sync_q;
    end
  end

  assign start = send_sync_q & ~send_prev_q;

  // Outputs are registered, so look up the byte that goes out next cycle.
  assign rom_idx = (state_q == StLoad) ? cnt_q + ADDR_W'(1) : '0;

  example_program_rom #(
    .IDX_W (ADDR_W)
  ) u_rom (
    .sel  (prog_sel_q),
    .idx  (rom_idx),
    .data (rom_data)
  );

  // Sequencer: state, word counter, latched program select and the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      prog_sel_q <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          wr_en   <= 1'b0;
          wr_addr <= '0;
          wr_data <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            prog_sel_q <= program_sel;
            wr_en      <= 1'b1;
            busy       <= 1'b1;
            if (edit) begin
              state_q <= StManual;
              wr_addr <= unit;
              wr_data <= code;
            end else begin
              state_q <= StClear;
              cnt_q   <= '0;
            end
          end
        end

        StManual: begin
          state_q <= StFin;
          wr_en   <= 1'b0;
          wr_addr <= '0;
          wr_data <= '0;
          done    <= 1'b1;
        end

        StClear: begin
          if (cnt_q == ADDR_W'(CLEAR_DEPTH - 1)) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            wr_addr <= '0;
            wr_data <= DATA_W'(rom_data);
          end else begin
            cnt_q   <= cnt_q + ADDR_W'(1);
            wr_addr <= cnt_q + ADDR_W'(1);
            wr_data <= '0;
          end
        end

        StLoad: begin
          if (cnt_q == ADDR_W'(PROG_LEN[prog_sel_q] - 1)) begin
            state_q <= StFin;
            cnt_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + ADDR_W'(1);
            wr_addr <= cnt_q + ADDR_W'(1);
            wr_data <= DATA_W'(rom_data);
          end
        end

        StFin: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          wr_en   <= 1'b0;
          wr_addr <= '0;
          wr_data <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
